spi_cmd_decoder: RTL and testbench

Consumes the 3-byte frames assembled by the SPI receiver stage: 24-bit frame plus a 1-cycle valid pulse. Decodes byte 0 as an opcode and bytes 1-2 as a 16-bit payload.
- Maintains a bank of 16-bit control registers (write / bit-set / bit-clear).
- Queues "event" opcodes into a small FIFO for a downstream consumer with a valid/ready handshake.
- Sits between the SPI receiver and the nextasic control logic. All logic is on clk posedge.

---
 rtl/spi_cmd_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
// -----------------------------------------------------------------------------
// spi_cmd_decoder
//   Decodes 3-byte SPI command frames into control-register updates and
//   queued events for a downstream consumer.
//
//   Frame layout: {opcode[7:0], data[15:0]}
//     opcode[7:6] = 11 WRITE, 10 SET (OR), 01 CLEAR (AND-NOT)
//                   register index in opcode[3:0], opcode[5:4] must be 00
//     opcode      = 00 NOP
//     opcode[7:6] = 00 (nonzero) EVENT, pushes {opcode[5:0], data}
//
//   Ports:
//     clk, reset_n          clock, asynchronous active-low reset
//     frame_in/_valid_in    24-bit frame and 1-cycle qualifier
//     regs_out              register bank, reg i at [16*i+15:16*i]
//     reg_write_strobe      1-cycle pulse per updated register
//     evt_code/evt_data     show-ahead head of the event FIFO
//     evt_valid/evt_ready   FIFO non-empty / consumer accept
//     evt_overflow          sticky drop flag, cleared by clear_overflow
//     bad_cmd               1-cycle pulse on an illegal register command
//     err_count             (SPI_CMD_ERR_COUNT_EN only) saturating count of
//                           bad commands plus dropped events
//
//   Optional feature macro: SPI_CMD_ERR_COUNT_EN
// -----------------------------------------------------------------------------
module spi_cmd_decoder #(
    parameter int NUM_REGS   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [23:0]              frame_in,
    input  logic                     frame_valid_in,
    output logic [16*NUM_REGS-1:0]   regs_out,
    output logic [NUM_REGS-1:0]      reg_write_strobe,
    output logic [5:0]               evt_code,
    output logic [15:0]              evt_data,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic                     evt_overflow,
    input  logic                     clear_overflow,
    output logic                     bad_cmd
`ifdef SPI_CMD_ERR_COUNT_EN
    ,
    output logic [7:0]               err_count
`endif
);

    localparam int               PTR_W      = $clog2(FIFO_DEPTH);
    localparam int               CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [4:0]       NUM_REGS_L = 5'(NUM_REGS);

    logic [15:0]          r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]  r_strobe;
    logic                 r_bad;
    logic [21:0]          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_ovf;

    logic [7:0]           w_op;
    logic [15:0]          w_data;
    logic [3:0]           w_addr;
    logic                 w_is_reg;
    logic                 w_addr_ok;
    logic                 w_bad;
    logic                 w_push_req;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push;
    logic                 w_drop;
    logic [15:0]          w_cur;
    logic [15:0]          w_new;
    logic [NUM_REGS-1:0]  w_strobe_nxt;

    // Frame field split and command classification.
    always_comb begin
        w_op       = frame_in[23:16];
        w_data     = frame_in[15:0];
        w_addr     = w_op[3:0];
        w_is_reg   = frame_valid_in && (w_op[7:6] != 2'b00);
        w_addr_ok  = (w_op[5:4] == 2'b00) && ({1'b0, w_addr} < NUM_REGS_L);
        w_bad      = w_is_reg && !w_addr_ok;
        w_push_req = frame_valid_in && (w_op[7:6] == 2'b00) && (w_op != 8'h00);
        w_full     = (r_count == FULL_CNT);
        // A pop requires a non-empty FIFO, so push+pop on empty is push only.
        w_pop      = (r_count != {CNT_W{1'b0}}) && evt_ready;
        // When full, a same-edge pop frees the slot the push needs.
        w_push     = w_push_req && (!w_full || w_pop);
        w_drop     = w_push_req && w_full && !w_pop;
    end

    // Read-modify-write value for the addressed register.
    always_comb begin
        w_cur        = 16'h0000;
        w_strobe_nxt = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cur           = (w_addr == 4'(i)) ? r_regs[i] : w_cur;
            w_strobe_nxt[i] = w_is_reg && w_addr_ok && (w_addr == 4'(i));
        end
        case (w_op[7:6])
            2'b11:   w_new = w_data;
            2'b10:   w_new = w_cur | w_data;
            2'b01:   w_new = w_cur & ~w_data;
            default: w_new = w_cur;
        endcase
    end

    // Register bank, write strobes and bad-command pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 16'h0000;
            end
            r_strobe <= {NUM_REGS{1'b0}};
            r_bad    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_strobe_nxt[i]) begin
                    r_regs[i] <= w_new;
                end
            end
            r_strobe <= w_strobe_nxt;
            r_bad    <= w_bad;
        end
    end

    // Event FIFO storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 22'h000000;
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_op[5:0], w_data};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end else begin
                r_count <= r_count;
            end
            // A drop on the same edge as a clear keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clear_overflow) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

`ifdef SPI_CMD_ERR_COUNT_EN
    logic [7:0] r_err_count;

    // Saturating error counter; an error on the clearing edge counts as one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= 8'h00;
        end else if (clear_overflow) begin
            r_err_count <= (w_bad || w_drop) ? 8'h01 : 8'h00;
        end else if ((w_bad || w_drop) && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'h01;
        end else begin
            r_err_count <= r_err_count;
        end
    end

    assign err_count = r_err_count;
`endif

    // Flatten the register bank onto the output bus.
    always_comb begin
        regs_out = {(16*NUM_REGS){1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_out[16*i +: 16] = r_regs[i];
        end
    end

    assign reg_write_strobe = r_strobe;
    assign bad_cmd          = r_bad;
    assign evt_valid        = (r_count != {CNT_W{1'b0}});
    assign evt_code         = r_mem[r_rd_ptr][21:16];
    assign evt_data         = r_mem[r_rd_ptr][15:0];
    assign evt_overflow     = r_ovf;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_decoder
//   Directed and randomized stimulus for spi_cmd_decoder, checked every cycle
//   against a queue-based behavioural model of the command set and event FIFO.
// -----------------------------------------------------------------------------
module tb_spi_cmd_decoder;

    localparam int NREG  = 8;
    localparam int DEPTH = 4;

    logic               clk;
    logic               reset_n;
    logic [23:0]        frame_in;
    logic               frame_valid_in;
    logic [16*NREG-1:0] regs_out;
    logic [NREG-1:0]    reg_write_strobe;
    logic [5:0]         evt_code;
    logic [15:0]        evt_data;
    logic               evt_valid;
    logic               evt_ready;
    logic               evt_overflow;
    logic               clear_overflow;
    logic               bad_cmd;
`ifdef SPI_CMD_ERR_COUNT_EN
    logic [7:0]         err_count;
`endif

    spi_cmd_decoder #(.NUM_REGS(NREG), .FIFO_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .frame_in         (frame_in),
        .frame_valid_in   (frame_valid_in),
        .regs_out         (regs_out),
        .reg_write_strobe (reg_write_strobe),
        .evt_code         (evt_code),
        .evt_data         (evt_data),
        .evt_valid        (evt_valid),
        .evt_ready        (evt_ready),
        .evt_overflow     (evt_overflow),
        .clear_overflow   (clear_overflow),
        .bad_cmd          (bad_cmd)
`ifdef SPI_CMD_ERR_COUNT_EN
        ,
        .err_count        (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [15:0]     m_regs [NREG];
    logic [21:0]     m_q [$];
    bit              m_ovf;
    logic [NREG-1:0] m_strobe;
    bit              m_bad;
    int              m_err;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [127:0] m_pack();
        logic [127:0] v;
        v = 128'h0;
        for (int i = 0; i < NREG; i++) v[16*i +: 16] = m_regs[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = 16'h0000;
        m_q.delete();
        m_ovf    = 1'b0;
        m_strobe = '0;
        m_bad    = 1'b0;
        m_err    = 0;
    endtask

    // Apply one clock edge worth of the command rules to the model.
    task automatic m_step(input bit fv, input logic [23:0] fr, input bit rdy, input bit clr);
        logic [7:0]  op;
        logic [15:0] d;
        int          a;
        bit          err;
        err      = 1'b0;
        m_strobe = '0;
        m_bad    = 1'b0;
        op       = fr[23:16];
        d        = fr[15:0];
        if (clr) m_ovf = 1'b0;
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (fv) begin
            if (op[7:6] != 2'b00) begin
                a = int'(op[3:0]);
                if (op[5:4] != 2'b00 || a >= NREG) begin
                    m_bad = 1'b1;
                    err   = 1'b1;
                end else begin
                    if (op[7:6] == 2'b11)      m_regs[a] = d;
                    else if (op[7:6] == 2'b10) m_regs[a] = m_regs[a] | d;
                    else                       m_regs[a] = m_regs[a] & ~d;
                    m_strobe[a] = 1'b1;
                end
            end else if (op != 8'h00) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back({op[5:0], d});
                end else begin
                    m_ovf = 1'b1;
                    err   = 1'b1;
                end
            end
        end
        if (clr)                       m_err = err ? 1 : 0;
        else if (err && m_err < 255)   m_err = m_err + 1;
    endtask

    task automatic check_all();
        logic [21:0] head;
        check_eq("regs_out", regs_out, m_pack());
        check_eq("strobe", reg_write_strobe, m_strobe);
        check_eq("bad_cmd", bad_cmd, m_bad);
        check_eq("evt_valid", evt_valid, m_q.size() > 0);
        check_eq("evt_overflow", evt_overflow, m_ovf);
        if (m_q.size() > 0) begin
            head = m_q[0];
            check_eq("evt_code", evt_code, head[21:16]);
            check_eq("evt_data", evt_data, head[15:0]);
        end
`ifdef SPI_CMD_ERR_COUNT_EN
        check_eq("err_count", err_count, m_err[7:0]);
`endif
    endtask

    task automatic do_cycle(input bit fv, input logic [23:0] fr, input bit rdy, input bit clr);
        frame_valid_in = fv;
        frame_in       = fr;
        evt_ready      = rdy;
        clear_overflow = clr;
        @(posedge clk);
        m_step(fv, fr, rdy, clr);
        #1;
        check_all();
    endtask

    task automatic check_reset_zero(input string tag);
        check_eq({tag, "_regs"}, regs_out, 128'h0);
        check_eq({tag, "_strobe"}, reg_write_strobe, 128'h0);
        check_eq({tag, "_valid"}, evt_valid, 128'h0);
        check_eq({tag, "_code"}, evt_code, 128'h0);
        check_eq({tag, "_data"}, evt_data, 128'h0);
        check_eq({tag, "_ovf"}, evt_overflow, 128'h0);
        check_eq({tag, "_bad"}, bad_cmd, 128'h0);
    endtask

    function automatic logic [23:0] rand_frame();
        int          r;
        logic [7:0]  op;
        logic [15:0] d;
        r = int'($urandom_range(0, 9));
        d = 16'($urandom);
        if (r == 0) begin
            op = 8'h00;
        end else if (r <= 3) begin
            op = {2'b00, 6'($urandom_range(1, 63))};
        end else begin
            op[7:6] = 2'($urandom_range(1, 3));
            op[5:4] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            op[3:0] = 4'($urandom_range(0, 15));
        end
        return {op, d};
    endfunction

    initial begin
        reset_n        = 1'b0;
        frame_in       = 24'h0;
        frame_valid_in = 1'b0;
        evt_ready      = 1'b0;
        clear_overflow = 1'b0;
        m_reset();
        #12;
        check_reset_zero("rst");
        #10 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write and its one-cycle strobe
        do_cycle(1'b1, 24'hC3_BEEF, 1'b0, 1'b0);
        check_eq("tp_reg3", regs_out[63:48], 16'hBEEF);
        check_eq("tp_strobe3", reg_write_strobe, 8'b0000_1000);
        check_eq("tp_nobad", bad_cmd, 1'b0);
        do_cycle(1'b0, 24'h0, 1'b0, 1'b0);
        check_eq("tp_strobe_off", reg_write_strobe, 8'h00);

        // Set then clear on reg1
        do_cycle(1'b1, 24'hC1_00F0, 1'b0, 1'b0);
        do_cycle(1'b1, 24'h81_0F00, 1'b0, 1'b0);
        check_eq("tp_set", regs_out[31:16], 16'h0FF0);
        do_cycle(1'b1, 24'h41_00F0, 1'b0, 1'b0);
        check_eq("tp_clr", regs_out[31:16], 16'h0F00);

        // Illegal commands and NOP
        do_cycle(1'b1, 24'hCA_1234, 1'b0, 1'b0);
        check_eq("tp_bad_addr", bad_cmd, 1'b1);
        do_cycle(1'b1, 24'hD0_1234, 1'b0, 1'b0);
        check_eq("tp_bad_op54", bad_cmd, 1'b1);
        check_eq("tp_bad_strobe", reg_write_strobe, 8'h00);
        do_cycle(1'b1, 24'h00_FFFF, 1'b0, 1'b0);
        check_eq("tp_nop_bad", bad_cmd, 1'b0);
        check_eq("tp_nop_valid", evt_valid, 1'b0);

        // Fill past capacity
        for (int k = 1; k <= 5; k++) do_cycle(1'b1, {8'h05, 16'(k)}, 1'b0, 1'b0);
        check_eq("tp_fill_valid", evt_valid, 1'b1);
        check_eq("tp_fill_code", evt_code, 6'h05);
        check_eq("tp_fill_data", evt_data, 16'h0001);
        check_eq("tp_fill_ovf", evt_overflow, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            check_eq("tp_drain", evt_data, 16'(k));
            do_cycle(1'b0, 24'h0, 1'b1, 1'b0);
        end
        check_eq("tp_drained", evt_valid, 1'b0);

        // Full FIFO with push and pop on the same edge
        do_cycle(1'b0, 24'h0, 1'b0, 1'b1);
        check_eq("tp_ovf_clr", evt_overflow, 1'b0);
        for (int k = 0; k < 4; k++) do_cycle(1'b1, {8'h05, 16'(16'h0011 + k)}, 1'b0, 1'b0);
        do_cycle(1'b1, 24'h05_0015, 1'b1, 1'b0);
        check_eq("tp_pp_ovf", evt_overflow, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check_eq("tp_pp_order", evt_data, 16'(16'h0012 + k));
            do_cycle(1'b0, 24'h0, 1'b1, 1'b0);
        end
        check_eq("tp_pp_empty", evt_valid, 1'b0);

        // Randomized traffic, back-to-back frames allowed
        for (int c = 0; c < 1500; c++) begin
            do_cycle(($urandom_range(0, 2) == 0), rand_frame(),
                     $urandom_range(0, 1) == 1, ($urandom_range(0, 19) == 0));
        end

        // Reset in the middle of activity
        do_cycle(1'b1, 24'hC2_A5A5, 1'b0, 1'b0);
        do_cycle(1'b1, 24'h07_1111, 1'b0, 1'b0);
        do_cycle(1'b1, 24'hC5_0001, 1'b0, 1'b0);
        #3 reset_n = 1'b0;
        #1;
        check_reset_zero("midrst");
        m_reset();
        frame_valid_in = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        do_cycle(1'b1, 24'hC0_1357, 1'b0, 1'b0);
        do_cycle(1'b1, 24'h01_2468, 1'b0, 1'b0);
        for (int c = 0; c < 300; c++) begin
            do_cycle(($urandom_range(0, 2) == 0), rand_frame(),
                     $urandom_range(0, 1) == 1, ($urandom_range(0, 19) == 0));
        end

`ifdef SPI_CMD_ERR_COUNT_EN
        do_cycle(1'b0, 24'h0, 1'b0, 1'b1);
        for (int c = 0; c < 300; c++) do_cycle(1'b1, 24'hCA_1234, 1'b0, 1'b0);
        check_eq("tp_err_sat", err_count, 8'hFF);
        do_cycle(1'b1, 24'hCA_1234, 1'b0, 1'b1);
        check_eq("tp_err_clr_win", err_count, 8'h01);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
